// File: rtl/k005297_pkg.sv
// Shared arbiter state encoding and parameter defaults for the K005297 DMA bus arbiter.
package k005297_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_SYNC = 3'd2,
    ST_OWN  = 3'd3,
    ST_REL  = 3'd4,
    ST_GAP  = 3'd5
  } arb_state_e;

  localparam int BURST_MAX_DEF   = 4;
  localparam int GAP_CYC_DEF     = 8;
  localparam int GNT_TIMEOUT_DEF = 63;

endpackage

// File: rtl/k005297_edgedet.sv
// Rising-edge detector that samples its input only on 4 MHz enables.
module k005297_edgedet (
  input  logic i_MCLK,
  input  logic i_SYS_RST,
  input  logic i_EN,
  input  logic i_D,
  output logic o_RISE
);

  logic d_prev;

  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST)
      d_prev <= 1'b0;
    else if (i_EN)
      d_prev <= i_D;
  end

  assign o_RISE = i_EN & i_D & ~d_prev;

endmodule

// File: rtl/k005297_busarb.sv
// DMA bus arbiter: requests the CPU bus, owns it for a burst, then releases it.
//  state | meaning
//  IDLE  | bus not wanted
//  REQ   | BR asserted, waiting for BG (grant timer running)
//  SYNC  | granted, waiting for AS and foreign BGACK to go idle
//  OWN   | bus owned, DMA running, words counted
//  REL   | one enable holding BGACK after DMA stops
//  GAP   | forced bus-free gap after a burst-limited release
module k005297_busarb #(
  parameter int BURST_MAX   = k005297_pkg::BURST_MAX_DEF,
  parameter int GAP_CYC     = k005297_pkg::GAP_CYC_DEF,
  parameter int GNT_TIMEOUT = k005297_pkg::GNT_TIMEOUT_DEF
) (
  input  logic       i_MCLK,
  input  logic       i_SYS_RST,
  input  logic       i_CLK4M_PCEN_n,
  input  logic       i_BR_START_n,
  input  logic       i_DMA_END,
  input  logic       i_DMA_WORD_END,
  input  logic       i_BG_n,
  input  logic       i_AS_n,
  input  logic       i_BGACK_n,
  output logic       o_BR_n,
  output logic       o_BGACK_n,
  output logic       o_DMA_ACT,
  output logic       o_GNT_TO,
  output logic [3:0] o_WORD_CNT
);
  import k005297_pkg::*;

  logic       en;
  logic       word_rise;
  arb_state_e state, state_nxt;
  logic [5:0] gnt_tmr, gnt_tmr_nxt;
  logic [3:0] gap_tmr, gap_tmr_nxt;
  logic [3:0] word_cnt_nxt;
  logic       limit_flg, limit_flg_nxt;
  logic       gnt_to_nxt;

  assign en = ~i_CLK4M_PCEN_n;

  k005297_edgedet u_word_edge (
    .i_MCLK   (i_MCLK),
    .i_SYS_RST(i_SYS_RST),
    .i_EN     (en),
    .i_D      (i_DMA_WORD_END),
    .o_RISE   (word_rise)
  );

  always_comb begin
    state_nxt     = state;
    gnt_tmr_nxt   = gnt_tmr;
    gap_tmr_nxt   = gap_tmr;
    word_cnt_nxt  = o_WORD_CNT;
    limit_flg_nxt = limit_flg;
    gnt_to_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!i_BR_START_n) begin
          state_nxt    = ST_REQ;
          gnt_tmr_nxt  = '0;
          word_cnt_nxt = '0;
        end
      end
      ST_REQ: begin
        gnt_tmr_nxt = gnt_tmr + 6'd1;
        // A grant arriving on the expiry enable still wins over the timeout.
        if (!i_BG_n) begin
          state_nxt = ST_SYNC;
        end else if (gnt_tmr_nxt == 6'(GNT_TIMEOUT)) begin
          state_nxt  = ST_IDLE;
          gnt_to_nxt = 1'b1;
        end
      end
      ST_SYNC: begin
        if (i_AS_n && i_BGACK_n)
          state_nxt = ST_OWN;
      end
      ST_OWN: begin
        if (word_rise && (o_WORD_CNT != 4'hF))
          word_cnt_nxt = o_WORD_CNT + 4'd1;
        if (i_DMA_END) begin
          state_nxt     = ST_REL;
          limit_flg_nxt = 1'b0;
        end else if (o_WORD_CNT >= 4'(BURST_MAX)) begin
          state_nxt     = ST_REL;
          limit_flg_nxt = 1'b1;
        end
      end
      ST_REL: begin
        state_nxt   = limit_flg ? ST_GAP : ST_IDLE;
        gap_tmr_nxt = '0;
      end
      ST_GAP: begin
        gap_tmr_nxt = gap_tmr + 4'd1;
        if (gap_tmr_nxt == 4'(GAP_CYC)) begin
          if (!i_BR_START_n) begin
            state_nxt    = ST_REQ;
            gnt_tmr_nxt  = '0;
            word_cnt_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they change on the same enabled edge.
  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST) begin
      state      <= ST_IDLE;
      gnt_tmr    <= '0;
      gap_tmr    <= '0;
      limit_flg  <= 1'b0;
      o_BR_n     <= 1'b1;
      o_BGACK_n  <= 1'b1;
      o_DMA_ACT  <= 1'b0;
      o_GNT_TO   <= 1'b0;
      o_WORD_CNT <= '0;
    end else if (en) begin
      state      <= state_nxt;
      gnt_tmr    <= gnt_tmr_nxt;
      gap_tmr    <= gap_tmr_nxt;
      limit_flg  <= limit_flg_nxt;
      o_BR_n     <= ~((state_nxt == ST_REQ) || (state_nxt == ST_SYNC));
      o_BGACK_n  <= ~((state_nxt == ST_OWN) || (state_nxt == ST_REL));
      o_DMA_ACT  <= (state_nxt == ST_OWN);
      o_GNT_TO   <= gnt_to_nxt;
      o_WORD_CNT <= word_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_k005297_busarb.sv
// Directed bench for k005297_busarb: vector table plus timeout and reset sequences.
module tb_k005297_busarb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pcen_n = 1'b1;
  logic       br_start_n = 1'b1;
  logic       dma_end = 1'b0;
  logic       word_end = 1'b0;
  logic       bg_n = 1'b1;
  logic       as_n = 1'b1;
  logic       bgack_in_n = 1'b1;
  logic       o_BR_n, o_BGACK_n, o_DMA_ACT, o_GNT_TO;
  logic [3:0] o_WORD_CNT;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  k005297_busarb dut (
    .i_MCLK        (clk),
    .i_SYS_RST     (rst),
    .i_CLK4M_PCEN_n(pcen_n),
    .i_BR_START_n  (br_start_n),
    .i_DMA_END     (dma_end),
    .i_DMA_WORD_END(word_end),
    .i_BG_n        (bg_n),
    .i_AS_n        (as_n),
    .i_BGACK_n     (bgack_in_n),
    .o_BR_n        (o_BR_n),
    .o_BGACK_n     (o_BGACK_n),
    .o_DMA_ACT     (o_DMA_ACT),
    .o_GNT_TO      (o_GNT_TO),
    .o_WORD_CNT    (o_WORD_CNT)
  );

  // ins  = {br_start_n, dma_end, word_end, bg_n, as_n, bgack_n}
  // outs = {br_n, bgack_n, dma_act, gnt_to}
  typedef struct {
    logic [5:0] ins;
    logic [3:0] outs;
    logic [3:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [5:0] i, input logic [3:0] o, input logic [3:0] c);
    vec_t v;
    v.ins  = i;
    v.outs = o;
    v.cnt  = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] o, input logic [3:0] c);
    chk({tag, ".br_n"},    4'(o_BR_n),    4'(o[3]));
    chk({tag, ".bgack_n"}, 4'(o_BGACK_n), 4'(o[2]));
    chk({tag, ".dma_act"}, 4'(o_DMA_ACT), 4'(o[1]));
    chk({tag, ".gnt_to"},  4'(o_GNT_TO),  4'(o[0]));
    chk({tag, ".cnt"},     o_WORD_CNT,    c);
  endtask

  task automatic drive(input logic [5:0] i);
    {br_start_n, dma_end, word_end, bg_n, as_n, bgack_in_n} = i;
  endtask

  task automatic tick(input logic en);
    @(negedge clk);
    pcen_n = ~en;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      n_chk++;
      if (!o_BR_n && !o_BGACK_n) begin
        n_fail++;
        $display("FAIL br_bgack_excl: BR_n=%b BGACK_n=%b, both low not allowed", o_BR_n, o_BGACK_n);
      end
    end
  end

  initial begin
    // Grant after 3 enables, two words, DMA end, back to idle.
    vq.push_back(mk(6'b000111, 4'b0100, 4'd0));
    vq.push_back(mk(6'b000111, 4'b0100, 4'd0));
    vq.push_back(mk(6'b000111, 4'b0100, 4'd0));
    vq.push_back(mk(6'b000011, 4'b0100, 4'd0));
    vq.push_back(mk(6'b100011, 4'b1010, 4'd0));
    vq.push_back(mk(6'b101111, 4'b1010, 4'd1));
    vq.push_back(mk(6'b101111, 4'b1010, 4'd1));
    vq.push_back(mk(6'b100111, 4'b1010, 4'd1));
    vq.push_back(mk(6'b101111, 4'b1010, 4'd2));
    vq.push_back(mk(6'b110111, 4'b1000, 4'd2));
    vq.push_back(mk(6'b100111, 4'b1100, 4'd2));
    vq.push_back(mk(6'b100111, 4'b1100, 4'd2));
    // Burst limit of 4, SYNC waits on AS and foreign BGACK, 8-enable gap, re-request.
    vq.push_back(mk(6'b000111, 4'b0100, 4'd0));
    vq.push_back(mk(6'b000011, 4'b0100, 4'd0));
    vq.push_back(mk(6'b000001, 4'b0100, 4'd0));
    vq.push_back(mk(6'b000010, 4'b0100, 4'd0));
    vq.push_back(mk(6'b000011, 4'b1010, 4'd0));
    for (int w = 1; w <= 4; w++) begin
      vq.push_back(mk(6'b001111, 4'b1010, 4'(w)));
      if (w < 4) vq.push_back(mk(6'b000111, 4'b1010, 4'(w)));
    end
    vq.push_back(mk(6'b000111, 4'b1000, 4'd4));
    vq.push_back(mk(6'b000111, 4'b1100, 4'd4));
    for (int g = 1; g <= 7; g++) vq.push_back(mk(6'b000111, 4'b1100, 4'd4));
    vq.push_back(mk(6'b000111, 4'b0100, 4'd0));
    vq.push_back(mk(6'b100011, 4'b0100, 4'd0));
    vq.push_back(mk(6'b100011, 4'b1010, 4'd0));
    vq.push_back(mk(6'b110111, 4'b1000, 4'd0));
    vq.push_back(mk(6'b100111, 4'b1100, 4'd0));
    // DMA end together with the 4th word: IDLE, so a request is taken at once.
    vq.push_back(mk(6'b000111, 4'b0100, 4'd0));
    vq.push_back(mk(6'b100011, 4'b0100, 4'd0));
    vq.push_back(mk(6'b100011, 4'b1010, 4'd0));
    for (int w = 1; w <= 3; w++) begin
      vq.push_back(mk(6'b101111, 4'b1010, 4'(w)));
      vq.push_back(mk(6'b100111, 4'b1010, 4'(w)));
    end
    vq.push_back(mk(6'b111111, 4'b1000, 4'd4));
    vq.push_back(mk(6'b100111, 4'b1100, 4'd4));
    vq.push_back(mk(6'b000111, 4'b0100, 4'd0));
    vq.push_back(mk(6'b100111, 4'b0100, 4'd0));
    // Count already at limit when DMA end arrives: end flag wins.
    vq.push_back(mk(6'b100011, 4'b0100, 4'd0));
    vq.push_back(mk(6'b100011, 4'b1010, 4'd0));
    for (int w = 1; w <= 4; w++) begin
      vq.push_back(mk(6'b101111, 4'b1010, 4'(w)));
      if (w < 4) vq.push_back(mk(6'b100111, 4'b1010, 4'(w)));
    end
    vq.push_back(mk(6'b110111, 4'b1000, 4'd4));
    vq.push_back(mk(6'b000111, 4'b1100, 4'd4));
    vq.push_back(mk(6'b000111, 4'b0100, 4'd0));

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 4'b1100, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].ins);
      tick(1'b1);
      check_outs($sformatf("vec%0d", k), vq[k].outs, vq[k].cnt);
      tick(1'b0);
      check_outs($sformatf("vec%0d_hold", k), vq[k].outs, vq[k].cnt);
    end

    // Reset in OWN with the enable inactive releases the bus on that edge.
    drive(6'b100011);
    tick(1'b1);
    tick(1'b1);
    drive(6'b101111);
    tick(1'b1);
    check_outs("pre_rst_own", 4'b1010, 4'd1);
    rst = 1'b1;
    tick(1'b0);
    check_outs("mid_rst", 4'b1100, 4'd0);
    rst = 1'b0;
    drive(6'b100111);
    tick(1'b1);
    check_outs("post_rst_idle", 4'b1100, 4'd0);

    // Grant never arrives: single timeout pulse on the 63rd REQ enable.
    drive(6'b000111);
    tick(1'b1);
    drive(6'b100111);
    for (int n = 1; n <= 64; n++) begin
      tick(1'b1);
      chk($sformatf("to_gnt_to_n%0d", n), 4'(o_GNT_TO), 4'(n == 63));
      chk($sformatf("to_br_n_n%0d", n), 4'(o_BR_n), 4'(n >= 63));
    end

    // Grant on the expiry enable goes to SYNC without a timeout.
    drive(6'b000111);
    tick(1'b1);
    drive(6'b100111);
    for (int n = 1; n <= 62; n++) tick(1'b1);
    drive(6'b100011);
    tick(1'b1);
    check_outs("gnt_at_expiry", 4'b0100, 4'd0);
    tick(1'b1);
    check_outs("gnt_at_expiry_own", 4'b1010, 4'd0);
    drive(6'b110111);
    tick(1'b1);
    drive(6'b100111);
    tick(1'b1);
    check_outs("gnt_at_expiry_idle", 4'b1100, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/k005297_busarb.md
K005297_BUSARB -- requirements
Module: K005297_busarb

Interface
REQ-001 SHALL have parameter BURST_MAX, default 4, max DMA words per bus tenure (1..15).
REQ-002 SHALL have parameter GAP_CYC, default 8, 4 MHz enables of bus-free gap after a burst-limited release (1..15).
REQ-003 SHALL have parameter GNT_TIMEOUT, default 63, 4 MHz enables to wait for grant before abort (1..63).
REQ-004 i_MCLK  in  1  master clock; single clock domain, all state changes on its rising edge.
REQ-005 i_SYS_RST  in  1  reset, synchronous, active-high.
REQ-006 i_CLK4M_PCEN_n  in  1  4 MHz clock enable, active-low; state advances only when low.
REQ-007 i_BR_START_n  in  1  DMA start request from the DMA timing block, active-low level.
REQ-008 i_DMA_END  in  1  DMA sequence finished, active-high level.
REQ-009 i_DMA_WORD_END  in  1  one DMA word done, active-high; may last several enables.
REQ-010 i_BG_n  in  1  CPU bus grant, active-low.
REQ-011 i_AS_n  in  1  CPU address strobe, active-low; bus busy while low.
REQ-012 i_BGACK_n  in  1  bus-grant-acknowledge from other masters, active-low.
REQ-013 o_BR_n  out  1  bus request to CPU, active-low.
REQ-014 o_BGACK_n  out  1  this block owns bus, active-low.
REQ-015 o_DMA_ACT  out  1  DMA may run, active-high; feeds DMA timing i_DMA_ACT.
REQ-016 o_GNT_TO  out  1  grant-timeout pulse, one enable wide.
REQ-017 o_WORD_CNT  out  4  words transferred in current tenure.

Function
REQ-018 SHALL implement states IDLE, REQ, SYNC, OWN, REL, GAP; transitions only on enabled edges.
REQ-019 IDLE: all outputs inactive; i_BR_START_n=0 -> REQ, grant timer cleared.
REQ-020 REQ: o_BR_n=0; timer +1 per enable; i_BG_n=0 -> SYNC; else timer==GNT_TIMEOUT -> IDLE with o_GNT_TO=1 for that enable.
REQ-021 REQ: i_BG_n=0 and timer expiry on same enable -> SYNC, no o_GNT_TO.
REQ-022 SYNC: o_BR_n held 0; i_AS_n=1 and i_BGACK_n=1 sampled same enable -> OWN; no timeout in SYNC.
REQ-023 OWN: o_BR_n=1, o_BGACK_n=0, o_DMA_ACT=1, asserted from first enabled edge into OWN.
REQ-024 OWN: i_DMA_WORD_END rising edge (sampled per enable vs previous enable) -> o_WORD_CNT +1; level hold SHALL NOT recount.
REQ-025 OWN: i_DMA_END=1 -> REL, end flag set.
REQ-026 OWN: o_WORD_CNT reaching BURST_MAX -> REL, limit flag set; transition on the enable after the increment.
REQ-027 i_DMA_END and limit on same enable -> end flag wins (limit flag clear).
REQ-028 REL: o_DMA_ACT=0 immediately, o_BGACK_n stays 0 exactly one enable, then 1; next end flag -> IDLE, limit flag -> GAP.
REQ-029 GAP: outputs inactive; counter GAP_CYC enables; then i_BR_START_n=0 -> REQ, else IDLE.
REQ-030 o_WORD_CNT SHALL clear on entry to REQ; saturates at 15, no wrap.
REQ-031 o_BR_n and o_BGACK_n SHALL never both be 0 in OWN or REL.
REQ-032 Outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-033 i_SYS_RST=1 SHALL force IDLE on any i_MCLK edge regardless of i_CLK4M_PCEN_n.
REQ-034 Reset values: o_BR_n=1, o_BGACK_n=1, o_DMA_ACT=0, o_GNT_TO=0, o_WORD_CNT=0, timers and edge detector 0.
REQ-035 Reset mid-tenure SHALL release bus on the same edge (o_BGACK_n=1, o_DMA_ACT=0), no REL cycle.

Structure
REQ-036 State encoding and parameter default values SHALL reside in shared package K005297_pkg.
REQ-037 Single module; one natural sub-module K005297_edgedet (enabled rising-edge detector) for i_DMA_WORD_END.

Verification
REQ-038 i_BR_START_n=0, i_BG_n=0 after 3 enables, i_AS_n=1 -> o_BR_n low 4 enables, o_BGACK_n=0/o_DMA_ACT=1 from 5th.
REQ-039 In OWN, 2 word pulses then i_DMA_END=1 -> o_WORD_CNT=2, o_BGACK_n released one enable after o_DMA_ACT fall, IDLE.
REQ-040 BURST_MAX=4, i_DMA_END=0, 4 word pulses -> REL, 8 idle enables, re-request with o_WORD_CNT=0.
REQ-041 i_BG_n held 1 -> o_GNT_TO single pulse at enable 63, o_BR_n=1 afterwards.
REQ-042 i_SYS_RST=1 in OWN with i_CLK4M_PCEN_n=1 -> all outputs at reset values on that edge.
REQ-043 i_DMA_END and 4th word pulse same enable -> IDLE, no GAP.
